// File: rtl/fifo_drain.sv
// Round-robin drain of the block array's serial readout: polls empty flags, issues one fifo_req,
// deserialises the returning word and holds it on a valid/ready port. Optional FIFO_DRAIN_PARITY_EN.
module fifo_drain #(
   parameter int NCHAN     = 12,
   parameter int WORD_BITS = 32,
   parameter int REQ_LAT   = 2
) (
   input  logic                 fifo_clk,
   input  logic                 fifo_rst,
   input  logic                 enable,
   input  logic [NCHAN:1]       fifo_empty,
   output logic [NCHAN:1]       fifo_req,
   input  logic                 fifo_bit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_BITS-1:0] out_data,
   output logic [3:0]           out_chan,
   output logic                 busy
`ifdef FIFO_DRAIN_PARITY_EN
   ,
   output logic                 out_perr
`endif
);

`ifdef FIFO_DRAIN_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int NBITS  = WORD_BITS + PAR_BITS;
   localparam int BCNT_W = $clog2(NBITS + 1);
   localparam int WCNT_W = (REQ_LAT > 1) ? $clog2(REQ_LAT) : 1;
   localparam logic [3:0] CH_LAST = 4'(NCHAN);
   localparam logic [3:0] CH_ONE  = 4'd1;

   typedef enum logic [2:0] {
      S_SCAN  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [3:0]          ptr;
   logic [3:0]          chan;
   logic [WCNT_W-1:0]   wcnt;
   logic [BCNT_W-1:0]   bcnt;
   logic [NBITS-1:0]    shreg;

   logic                grant_found;
   logic [3:0]          grant_chan;
   logic                can_grant;
   int                  rr_sum;
   logic [3:0]          rr_idx;

`ifdef FIFO_DRAIN_PARITY_EN
   // Even parity over word plus parity bit: a nonzero XOR flags a corrupted transfer.
   function automatic logic parity_err(input logic [NBITS-1:0] v);
      return ^v;
   endfunction
`endif

   // Round-robin search starting at ptr, wrapping NCHAN back to 1.
   always_comb begin
      grant_found = 1'b0;
      grant_chan  = 4'd0;
      rr_sum      = 0;
      rr_idx      = 4'd0;
      for (int i = 0; i < NCHAN; i++) begin
         rr_sum = int'(ptr) + i;
         if (rr_sum > NCHAN) rr_sum = rr_sum - NCHAN;
         rr_idx = rr_sum[3:0];
         if (!grant_found && !fifo_empty[rr_idx]) begin
            grant_found = 1'b1;
            grant_chan  = rr_idx;
         end
      end
   end

   // A grant needs the output buffer free now or being emptied this cycle.
   assign can_grant = enable && (!out_valid || out_ready) && grant_found;

   always_comb begin
      state_nxt = state;
      case (state)
         S_SCAN:  if (can_grant) state_nxt = S_REQ;
         S_REQ:   state_nxt = (REQ_LAT == 1) ? S_SHIFT : S_WAIT;
         S_WAIT:  if (wcnt <= WCNT_W'(1)) state_nxt = S_SHIFT;
         S_SHIFT: if (bcnt == BCNT_W'(NBITS - 1)) state_nxt = S_OUT;
         S_OUT:   state_nxt = S_SCAN;
         default: state_nxt = S_SCAN;
      endcase
   end

   always_comb begin
      fifo_req = '0;
      if (state == S_REQ) fifo_req[chan] = 1'b1;
   end

   assign busy = (state != S_SCAN);

   always_ff @(posedge fifo_clk) begin
      if (fifo_rst) begin
         state     <= S_SCAN;
         ptr       <= CH_ONE;
         chan      <= 4'd0;
         wcnt      <= '0;
         bcnt      <= '0;
         shreg     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= 4'd0;
`ifdef FIFO_DRAIN_PARITY_EN
         out_perr  <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            S_SCAN:  if (can_grant) chan <= grant_chan;
            S_REQ: begin
               wcnt <= WCNT_W'(REQ_LAT - 1);
               bcnt <= '0;
            end
            S_WAIT:  wcnt <= wcnt - WCNT_W'(1);
            S_SHIFT: begin
               shreg <= {shreg[NBITS-2:0], fifo_bit};
               bcnt  <= bcnt + BCNT_W'(1);
            end
            S_OUT:   ptr <= (chan == CH_LAST) ? CH_ONE : chan + CH_ONE;
            default: ;
         endcase

         // ---- output buffer stage ----
         if (state == S_OUT) begin
            out_valid <= 1'b1;
            out_data  <= shreg[NBITS-1:NBITS-WORD_BITS];
            out_chan  <= chan;
`ifdef FIFO_DRAIN_PARITY_EN
            out_perr  <= parity_err(shreg);
`endif
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a channel responder answers each fifo_req with a serial word,
// the main sequence checks grant order, latency, back-pressure, reset and (optionally) parity.
module tb_fifo_drain;

   localparam int NCHAN     = 12;
   localparam int WORD_BITS = 32;
   localparam int REQ_LAT   = 2;
`ifdef FIFO_DRAIN_PARITY_EN
   localparam int NB = WORD_BITS + 1;
`else
   localparam int NB = WORD_BITS;
`endif
   localparam int LAT    = REQ_LAT + NB + 1;
   localparam int PERIOD = REQ_LAT + NB + 2;

   logic                 fifo_clk;
   logic                 fifo_rst;
   logic                 enable;
   logic [NCHAN:1]       fifo_empty;
   logic [NCHAN:1]       fifo_req;
   logic                 fifo_bit;
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_BITS-1:0] out_data;
   logic [3:0]           out_chan;
   logic                 busy;
`ifdef FIFO_DRAIN_PARITY_EN
   logic                 out_perr;
`endif

   fifo_drain #(.NCHAN(NCHAN), .WORD_BITS(WORD_BITS), .REQ_LAT(REQ_LAT)) dut (
      .fifo_clk   (fifo_clk),
      .fifo_rst   (fifo_rst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_req   (fifo_req),
      .fifo_bit   (fifo_bit),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_chan   (out_chan),
      .busy       (busy)
`ifdef FIFO_DRAIN_PARITY_EN
      ,
      .out_perr   (out_perr)
`endif
   );

   initial fifo_clk = 1'b0;
   always #5 fifo_clk = ~fifo_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge fifo_clk) cyc <= cyc + 1;

   logic [31:0] word_tab [1:NCHAN];
   logic        flip_tab [1:NCHAN];
   int          req_chan_log[$];
   int          req_cyc_log[$];
   logic        multi = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge fifo_clk);
   endtask

   task automatic wait_req(output int n, input int lim);
      n = 0;
      while (fifo_req == '0 && n < lim) begin tick(1); n++; end
   endtask

   task automatic wait_valid(output int n, input int lim);
      n = 0;
      while (out_valid !== 1'b1 && n < lim) begin tick(1); n++; end
   endtask

   // Request monitor: logs grants and flags any cycle with more than one request.
   initial begin
      forever begin
         @(negedge fifo_clk);
         if ($countones(fifo_req) > 1) multi = 1'b1;
         if (fifo_req != '0) begin
            for (int k = 1; k <= NCHAN; k++)
               if (fifo_req[k]) begin
                  req_chan_log.push_back(k);
                  req_cyc_log.push_back(cyc);
               end
         end
      end
   end

   // Channel model: first bit appears REQ_LAT cycles after the request cycle, MSB first.
   initial begin
      int c;
      logic [NB-1:0] tx;
      fifo_bit = 1'b0;
      forever begin
         @(negedge fifo_clk);
         if (fifo_req != '0) begin
            c = 1;
            for (int k = 1; k <= NCHAN; k++) if (fifo_req[k]) c = k;
`ifdef FIFO_DRAIN_PARITY_EN
            tx = {word_tab[c], (^word_tab[c]) ^ flip_tab[c]};
`else
            tx = word_tab[c];
`endif
            repeat (REQ_LAT) @(negedge fifo_clk);
            for (int i = 0; i < NB; i++) begin
               fifo_bit = tx[NB-1-i];
               @(negedge fifo_clk);
            end
            fifo_bit = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic any_req, any_busy, any_valid, unstable;
      int exp_ch [4];
      logic [31:0] exp_wd [4];
      int out_ch_log[$];
      logic [31:0] out_wd_log[$];

      fifo_rst   = 1'b1;
      enable     = 1'b0;
      fifo_empty = '1;
      out_ready  = 1'b0;
      for (int k = 1; k <= NCHAN; k++) begin
         word_tab[k] = 32'h0;
         flip_tab[k] = 1'b0;
      end
      tick(3);
      chk("rst_req",   fifo_req,  0);
      chk("rst_busy",  busy,      0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data,  0);
      chk("rst_chan",  out_chan,  0);
      fifo_rst = 1'b0;
      enable   = 1'b1;

      // All empty: nothing must happen
      any_req = 0; any_busy = 0; any_valid = 0;
      repeat (50) begin
         tick(1);
         if (fifo_req != '0) any_req = 1;
         if (busy !== 1'b0) any_busy = 1;
         if (out_valid !== 1'b0) any_valid = 1;
      end
      chk("idle_req",   any_req,   0);
      chk("idle_busy",  any_busy,  0);
      chk("idle_valid", any_valid, 0);

      // Round robin over 3, 7, 12 starting from ptr=1
      word_tab[3]  = 32'h1234_5678;
      word_tab[7]  = 32'hDEAD_BEEF;
      word_tab[12] = 32'h8000_0001;
      exp_ch = '{3, 7, 12, 3};
      exp_wd = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0001, 32'h1234_5678};
      out_ready = 1'b1;
      req_chan_log.delete();
      req_cyc_log.delete();
      fifo_empty[3] = 1'b0; fifo_empty[7] = 1'b0; fifo_empty[12] = 1'b0;
      n = 0;
      while (req_chan_log.size() < 4 && n < 600) begin
         tick(1); n++;
         if (out_valid === 1'b1) begin out_ch_log.push_back(out_chan); out_wd_log.push_back(out_data); end
      end
      fifo_empty = '1;
      n = 0;
      while (out_ch_log.size() < 4 && n < 100) begin
         tick(1); n++;
         if (out_valid === 1'b1) begin out_ch_log.push_back(out_chan); out_wd_log.push_back(out_data); end
      end
      chk("rr_nreq",  req_chan_log.size(), 4);
      chk("rr_nword", out_ch_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), (i < req_chan_log.size()) ? req_chan_log[i] : 0, exp_ch[i]);
         chk($sformatf("rr_chan%0d", i), (i < out_ch_log.size()) ? out_ch_log[i] : 0, exp_ch[i]);
         chk($sformatf("rr_data%0d", i), (i < out_wd_log.size()) ? out_wd_log[i] : 32'h0, exp_wd[i]);
      end
      chk("rr_period", (req_cyc_log.size() > 1) ? req_cyc_log[1] - req_cyc_log[0] : 0, PERIOD);
      chk("rr_single_req", multi, 0);
      tick(2);
      out_ready = 1'b0;
      chk("rr_drained", out_valid, 0);

      // Single word on channel 5, latency from the request cycle
      word_tab[5] = 32'hA5C3_0F01;
      fifo_empty[5] = 1'b0;
      wait_req(n, 20);
      chk("ch5_req", fifo_req, 12'h010);
      fifo_empty[5] = 1'b1;
      wait_valid(n, 100);
      chk("ch5_lat",  n, LAT);
      chk("ch5_data", out_data, 32'hA5C3_0F01);
      chk("ch5_chan", out_chan, 5);

      // Back-pressure: word held, no new request while it sits unaccepted
      word_tab[3] = 32'h0F0F_F0F0;
      fifo_empty[3] = 1'b0;
      any_req = 0; unstable = 0;
      repeat (100) begin
         tick(1);
         if (fifo_req != '0) any_req = 1;
         if (out_valid !== 1'b1 || out_data !== 32'hA5C3_0F01 || out_chan !== 4'd5) unstable = 1;
      end
      chk("hold_noreq", any_req, 0);
      chk("hold_stable", unstable, 0);
      chk("hold_busy", busy, 0);
      out_ready = 1'b1;
      tick(1);
      chk("accept_req", fifo_req, 12'h004);
      chk("accept_valid", out_valid, 0);
      fifo_empty[3] = 1'b1;
      wait_valid(n, 100);
      chk("ch3_lat",  n, LAT);
      chk("ch3_data", out_data, 32'h0F0F_F0F0);
      chk("ch3_chan", out_chan, 3);

      // Reset in the middle of a channel 9 word
      word_tab[9] = 32'hFFFF_FFFF;
      word_tab[2] = 32'h0000_00FF;
      fifo_empty[9] = 1'b0;
      wait_req(n, 20);
      chk("ch9_req", fifo_req, 12'h100);
      tick(10);
      fifo_rst = 1'b1;
      tick(1);
      chk("mid_rst_req",   fifo_req,  0);
      chk("mid_rst_busy",  busy,      0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data",  out_data,  0);
      chk("mid_rst_chan",  out_chan,  0);
      fifo_rst = 1'b0;
      enable   = 1'b0;
      fifo_empty[2] = 1'b0;
      any_valid = 0; any_busy = 0;
      repeat (45) begin
         tick(1);
         if (out_valid !== 1'b0) any_valid = 1;
         if (busy !== 1'b0) any_busy = 1;
      end
      chk("post_rst_noword", any_valid, 0);
      chk("post_rst_idle",   any_busy,  0);
      enable = 1'b1;
      wait_req(n, 20);
      chk("post_rst_ptr", fifo_req, 12'h002);
      fifo_empty = '1;
      wait_valid(n, 100);
      chk("ch2_lat",  n, LAT);
      chk("ch2_data", out_data, 32'h0000_00FF);
      chk("ch2_chan", out_chan, 2);
      tick(2);

`ifdef FIFO_DRAIN_PARITY_EN
      // Parity: good parity bit, then a flipped one
      word_tab[1] = 32'h0000_0001;
      flip_tab[1] = 1'b0;
      fifo_empty[1] = 1'b0;
      wait_req(n, 20);
      chk("par_ok_req", fifo_req, 12'h001);
      fifo_empty[1] = 1'b1;
      wait_valid(n, 100);
      chk("par_ok_data", out_data, 32'h0000_0001);
      chk("par_ok_perr", out_perr, 0);
      tick(2);
      flip_tab[1] = 1'b1;
      fifo_empty[1] = 1'b0;
      wait_req(n, 50);
      chk("par_bad_req", fifo_req, 12'h001);
      fifo_empty[1] = 1'b1;
      wait_valid(n, 100);
      chk("par_bad_data", out_data, 32'h0000_0001);
      chk("par_bad_perr", out_perr, 1);
      tick(2);
`endif

      chk("single_req_all", multi, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Downstream consumer of the 12-block array's shared serial readout.
- Polls the per-block fifo_empty flags round-robin and pulses one fifo_req at a time.
- Deserialises the word that returns on the wired-OR fifo_bit line and presents it, tagged with its channel number, on a valid/ready output port.
- Sits in the fifo_clk domain between the block array and the host readout path.

Parameters:
- NCHAN, 12: number of channels, numbered 1..NCHAN.
- WORD_BITS, 32: bits per word returned on fifo_bit.
- REQ_LAT, 2: cycles from the fifo_req cycle to the first data bit on fifo_bit; must be >= 1.

Ports:
- fifo_clk  in  1  sole clock.
- fifo_rst  in  1  reset; synchronous, active-high.
- enable  in  1  allows new requests to start; does not abort a word in progress.
- fifo_empty  in  NCHAN (index 1..NCHAN)  per-channel empty flag, fifo_clk domain.
- fifo_req  out  NCHAN (index 1..NCHAN)  one-cycle read request per channel.
- fifo_bit  in  1  serial data, MSB first, wired-OR of all channels.
- out_valid  out  1  out_data/out_chan hold a word.
- out_ready  in  1  consumer accepts the word when high together with out_valid.
- out_data  out  WORD_BITS  deserialised word.
- out_chan  out  4  channel number of the word, 1..NCHAN.
- busy  out  1  FSM not in SCAN.

Behaviour:
- Reset: all outputs 0; FSM to SCAN; round-robin pointer ptr = 1; shift register and bit counter cleared.
- Reset mid-word abandons the word; no output is produced for it.
- Clock/reset, fixed: one clock, fifo_clk; reset fifo_rst is synchronous and active-high.
- SCAN:
  - Condition to grant: enable=1 and out_valid=0 (or the output is being accepted this cycle).
  - Grant the first channel c with fifo_empty[c]=0, searching ptr, ptr+1, ..., NCHAN, 1, ..., ptr-1.
  - On grant, latch c and go to REQ; otherwise stay in SCAN.
- REQ: exactly one cycle.
  - fifo_req[c]=1, all other fifo_req bits 0.
  - Load wait counter with REQ_LAT-1; go to WAIT, or straight to SHIFT if REQ_LAT=1.
- WAIT: decrement the counter; go to SHIFT when it reaches 0.
- SHIFT: WORD_BITS cycles.
  - Each cycle: shreg = {shreg[WORD_BITS-2:0], fifo_bit}.
  - The first SHIFT cycle is exactly REQ_LAT cycles after the REQ cycle.
  - After the last bit, go to OUT.
- OUT: one cycle.
  - out_data = shreg, out_chan = c, out_valid = 1.
  - ptr = c+1, wrapping NCHAN to 1.
  - Go to SCAN.
- Output register:
  - out_valid stays 1 and out_data/out_chan stay stable until out_valid & out_ready.
  - No new REQ is issued while an unaccepted word is held. The output is therefore a one-deep buffer and words are never dropped.
  - If acceptance and a SCAN grant happen in the same cycle, both occur; the next word lands in OUT after at least REQ_LAT+WORD_BITS+1 cycles.
- Empty-flag staleness: fifo_empty[c] is not sampled again for channel c until the FSM returns to SCAN. Channels must update the flag within REQ_LAT+WORD_BITS cycles of the request.
- Minimum per-word period: 1 (SCAN) + 1 (REQ) + (REQ_LAT-1) + WORD_BITS + 1 (OUT).
- enable falling mid-word: the word completes normally; no new grant is made afterwards.
- Out-of-range ptr values (13..15) cannot occur. Any illegal FSM state returns to SCAN.

Optional Feature:
- Macro: FIFO_DRAIN_PARITY_EN.
- When defined:
  - Each transfer carries WORD_BITS+1 bits; the final bit is even parity over the word.
  - SHIFT runs WORD_BITS+1 cycles.
  - Extra output out_perr (1 bit) is registered with out_data: 1 when the XOR of all WORD_BITS+1 received bits is 1. It is cleared on reset.
  - out_data excludes the parity bit.
- When undefined: no out_perr port and SHIFT length is WORD_BITS; timing is otherwise identical.

Test Plan:
1. Reset, then fifo_empty=all 1 and enable=1 for 50 cycles -> fifo_req stays 0, busy=0, out_valid=0.
2. fifo_empty[5]=0 only; channel drives 32'hA5C3_0F01 starting 2 cycles after fifo_req[5] -> out_valid with out_data=32'hA5C3_0F01 and out_chan=5, exactly 35 cycles after the req cycle.
3. Channels 3, 7 and 12 all non-empty, ptr=1, out_ready=1 -> grants in order 3, 7, 12, 3; never two fifo_req bits high in the same cycle.
4. out_ready=0 after the first word -> out_valid held, data stable, and no fifo_req for 100 cycles. Raising out_ready -> the next fifo_req issues the same cycle.
5. Assert fifo_rst during SHIFT of a word on channel 9 -> the next cycle shows all outputs 0. After release the FSM is back in SCAN with ptr=1 and no partial word is output.
6. With FIFO_DRAIN_PARITY_EN defined: send 32'h0000_0001 with parity bit 1 -> out_perr=0. Send the same word with parity bit 0 -> out_perr=1.
